// File: rtl/mmio_rsp_timeout_ctrl.sv
// MMIO responder front end: decodes BAR into FME/Port region, issues one CSR request
// at a time, and returns tagged read completions with an all-ones error on timeout.
module mmio_rsp_timeout_ctrl #(
    parameter int unsigned TID_WIDTH      = 6,
    parameter int unsigned ADDR_WIDTH     = 20,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter logic [2:0]  FME_BAR        = 3'd0,
    parameter logic [2:0]  PORT_BAR       = 3'd2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h_req_valid,
    output logic                  h_req_ready,
    input  logic                  h_req_write,
    input  logic [2:0]            h_req_bar,
    input  logic [TID_WIDTH-1:0]  h_req_tid,
    input  logic [ADDR_WIDTH-1:0] h_req_addr,
    input  logic [DATA_WIDTH-1:0] h_req_wdata,
    output logic                  csr_req_valid,
    output logic                  csr_req_write,
    output logic                  csr_req_region,
    output logic [ADDR_WIDTH-1:0] csr_req_addr,
    output logic [DATA_WIDTH-1:0] csr_req_wdata,
    input  logic                  csr_ack_valid,
    input  logic [DATA_WIDTH-1:0] csr_ack_data,
    output logic                  h_rsp_valid,
    input  logic                  h_rsp_ready,
    output logic [TID_WIDTH-1:0]  h_rsp_tid,
    output logic [DATA_WIDTH-1:0] h_rsp_data,
    output logic                  h_rsp_err,
    output logic [15:0]           timeout_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RSP   = 2'd3;

    localparam logic [15:0]           WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'(7);

    logic [1:0]            state_q,    state_d;
    logic [TID_WIDTH-1:0]  tid_q,      tid_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic                  write_q,    write_d;
    logic                  region_q,   region_d;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q,  rsp_err_d;
    logic [15:0]           to_cnt_q,   to_cnt_d;
    logic                  bar_ok;

    assign bar_ok = (h_req_bar == FME_BAR) || (h_req_bar == PORT_BAR);

    always_comb begin
        state_d    = state_q;
        tid_d      = tid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        region_d   = region_q;
        wait_cnt_d = wait_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        to_cnt_d   = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (h_req_valid) begin
                    if (bar_ok) begin
                        tid_d    = h_req_tid;
                        addr_d   = h_req_addr & ~LOW_MASK;
                        wdata_d  = h_req_wdata;
                        write_d  = h_req_write;
                        region_d = (h_req_bar == PORT_BAR);
                        state_d  = ST_ISSUE;
                    end else if (!h_req_write) begin
                        // Unsupported-BAR read completes immediately; writes are dropped.
                        tid_d      = h_req_tid;
                        rsp_data_d = '1;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RSP;
                    end
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = write_q ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (csr_ack_valid) begin
                    rsp_data_d = csr_ack_data;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RSP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_data_d = '1;
                    rsp_err_d  = 1'b1;
                    to_cnt_d   = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
                    state_d    = ST_RSP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_RSP: begin
                if (h_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tid_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            region_q   <= 1'b0;
            wait_cnt_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            tid_q      <= tid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            region_q   <= region_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign h_req_ready    = (state_q == ST_IDLE);
    assign csr_req_valid  = (state_q == ST_ISSUE);
    assign csr_req_write  = write_q;
    assign csr_req_region = region_q;
    assign csr_req_addr   = addr_q;
    assign csr_req_wdata  = wdata_q;
    assign h_rsp_valid    = (state_q == ST_RSP);
    assign h_rsp_tid      = tid_q;
    assign h_rsp_data     = rsp_data_q;
    assign h_rsp_err      = rsp_err_q;
    assign timeout_cnt    = to_cnt_q;

endmodule
